// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit sitting beside the ALU in EX.
// Owns the architectural HI/LO registers. MULT/MULTU/DIV/DIVU take 33 cycles
// (accept edge, 32 iterations, then a DONE cycle that applies the sign fix-up
// and writes back). MTHI/MTLO write HI/LO in one cycle without going busy.
//
// Ports:
//   clk_i    - clock, all state on rising edge
//   rst_ni   - asynchronous active-low reset
//   start_i  - request strobe, sampled only while idle
//   op_i     - 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, else none
//   a_i      - rs operand (multiplicand / dividend / MTHI-MTLO source)
//   b_i      - rt operand (multiplier / divisor)
//   flush_i  - aborts an in-flight operation and blocks a same-cycle accept
//   busy_o   - high whenever not idle; stalls IF/ID/EX
//   done_o   - high during the DONE cycle (suppressed by flush_i)
//   hi_o     - HI register
//   lo_o     - LO register
module muldiv_unit #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 5
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             flush_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam logic [2:0] OpMult  = 3'b001;
   localparam logic [2:0] OpMultu = 3'b010;
   localparam logic [2:0] OpDiv   = 3'b011;
   localparam logic [2:0] OpDivu  = 3'b100;
   localparam logic [2:0] OpMthi  = 3'b101;
   localparam logic [2:0] OpMtlo  = 3'b110;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   // Multiply: {partial product, remaining multiplier bits}.
   // Divide:   {partial remainder, dividend bits / quotient bits}.
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   // Multiplicand for multiply, divisor for divide.
   logic [WIDTH-1:0]     opnd_q, opnd_d;
   logic                 is_div_q, is_div_d;
   logic                 neg_q_q, neg_q_d;  // negate product / quotient
   logic                 neg_r_q, neg_r_d;  // negate remainder

   // Operand decode at accept
   logic                 signed_op, div_op;
   logic [WIDTH-1:0]     a_mag, b_mag;

   assign signed_op = (op_i == OpMult) || (op_i == OpDiv);
   assign div_op    = (op_i == OpDiv) || (op_i == OpDivu);
   assign a_mag     = (signed_op && a_i[WIDTH-1]) ? -a_i : a_i;
   assign b_mag     = (signed_op && b_i[WIDTH-1]) ? -b_i : b_i;

   // One shift-add multiply step: add multiplicand if LSB set, shift right.
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_step;

   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                     (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
   assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

   // One restoring divide step: shift left, trial subtract, keep if non-negative.
   logic [WIDTH:0]       div_rem_sh, div_diff;
   logic                 div_ge;
   logic [2*WIDTH-1:0]   div_step;

   assign div_rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
   assign div_diff   = div_rem_sh - {1'b0, opnd_q};
   assign div_ge     = ~div_diff[WIDTH];
   assign div_step   = div_ge ? {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                              : {acc_q[2*WIDTH-2:0], 1'b0};

   // Sign fix-up applied in DONE
   logic [2*WIDTH-1:0]   prod_fix;
   logic [WIDTH-1:0]     quo_fix, rem_fix;

   assign prod_fix = neg_q_q ? -acc_q : acc_q;
   assign quo_fix  = neg_q_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
   assign rem_fix  = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      is_div_d = is_div_q;
      neg_q_d  = neg_q_q;
      neg_r_d  = neg_r_q;

      case (state_q)
         StIdle: begin
            if (start_i && !flush_i) begin
               case (op_i)
                  OpMthi: hi_d = a_i;
                  OpMtlo: lo_d = a_i;
                  OpMult, OpMultu, OpDiv, OpDivu: begin
                     state_d  = StRun;
                     cnt_d    = '0;
                     is_div_d = div_op;
                     if (div_op && (b_i == '0)) begin
                        // Divide by zero: subtracting zero every step leaves the
                        // raw dividend as remainder and an all-ones quotient.
                        acc_d   = {{WIDTH{1'b0}}, a_i};
                        opnd_d  = '0;
                        neg_q_d = 1'b0;
                        neg_r_d = 1'b0;
                     end else begin
                        acc_d   = {{WIDTH{1'b0}}, div_op ? a_mag : b_mag};
                        opnd_d  = div_op ? b_mag : a_mag;
                        neg_q_d = signed_op & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                        neg_r_d = signed_op & a_i[WIDTH-1];
                     end
                  end
                  default: ;
               endcase
            end
         end
         StRun: begin
            if (flush_i) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               acc_d = is_div_q ? div_step : mul_step;
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  state_d = StDone;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
            if (!flush_i) begin
               hi_d = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
               lo_d = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         is_div_q <= 1'b0;
         neg_q_q  <= 1'b0;
         neg_r_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         is_div_q <= is_div_d;
         neg_q_q  <= neg_q_d;
         neg_r_q  <= neg_r_d;
      end
   end

   assign busy_o = (state_q != StIdle);
   assign done_o = (state_q == StDone) && !flush_i;
   assign hi_o   = hi_q;
   assign lo_o   = lo_q;

endmodule
